clint_timer: RTL
================

CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have parameter PRESCALER, default 1, meaning core clock cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  core clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port enable_i  input  1  bus access request, sampled every cycle.
REQ-005 SHALL have port write_enable_i  input  4  byte write strobes; 0000 = read, otherwise write.
REQ-006 SHALL have port address_i  input  5  byte offset; bits [1:0] ignored.
REQ-007 SHALL have port data_i  input  32  write data.
REQ-008 SHALL have port data_o  output  32  read data.
REQ-009 SHALL have port mti_o  output  1  machine timer interrupt request (cause M_TIM_INT).
REQ-010 SHALL have port msi_o  output  1  machine software interrupt request (cause M_SW_INT).

Function
REQ-011 SHALL map registers by word offset: 0x00 msip (bit 0 only, rest read 0), 0x04 mtimecmp[31:0], 0x08 mtimecmp[63:32], 0x0C mtime[31:0], 0x10 mtime[63:32].
REQ-012 SHALL ignore writes to unmapped offsets 0x14..0x1C and return 0 on reads from them.
REQ-013 SHALL apply a write in the same cycle enable_i=1: byte lane n updated from data_i[8n+7:8n] only when write_enable_i[n]=1.
REQ-014 SHALL have a read latency of one cycle: data_o presents the addressed register value sampled in the request cycle, on the following cycle.
REQ-015 SHALL hold data_o unchanged in cycles with no read request.
REQ-016 SHALL leave data_o unchanged on write cycles.
REQ-017 SHALL keep a prescaler counter counting 0..PRESCALER-1 that wraps to 0.
REQ-018 SHALL generate a tick on each wrap of the prescaler counter; with PRESCALER=1, a tick every cycle.
REQ-019 SHALL increment 64-bit mtime by 1 on each tick, with carry from bit 31 into bit 32 in the same cycle.
REQ-020 SHALL wrap mtime from 0xFFFFFFFF_FFFFFFFF to 0.
REQ-021 SHALL suppress the increment when a write to either mtime half coincides with a tick; that cycle mtime = merged written value, with no carry into the unwritten half.
REQ-022 SHALL NOT reset or pause the prescaler counter on a write to mtime.
REQ-023 SHALL register mti_o each cycle as (mtime >= mtimecmp), unsigned 64-bit comparison on the current register values; mti_o lags any change by exactly one cycle.
REQ-024 SHALL keep mti_o asserted while the condition holds; it is cleared only by software raising mtimecmp or lowering mtime.
REQ-025 SHALL drive msi_o combinationally from msip bit 0.
REQ-026 SHALL make a read of a register in the same cycle as its update return the pre-update value.

Reset
REQ-027 SHALL, while reset_n=0, force mtime=0, mtimecmp=0xFFFFFFFF_FFFFFFFF, msip=0, prescaler counter=0, data_o=0, mti_o=0, msi_o=0.
REQ-028 SHALL, on reset assertion mid-operation (including during a pending read), discard the pending read and all register contents immediately, without waiting for a clock edge.
REQ-029 SHALL resume ticking on the first rising edge after reset_n deasserts; mtime reads 1 after PRESCALER edges.

Verification
REQ-030 Bench SHALL check the free-run scenario: PRESCALER=4, reset released, 40 cycles -> read mtime[31:0] = 10 (±1 for read-sample cycle), mtime[63:32] = 0, mti_o=0.
REQ-031 Bench SHALL check the compare scenario: mtime=0, write mtimecmp lo=20, hi=0, PRESCALER=1 -> mti_o rises exactly one cycle after mtime reaches 20; writing mtimecmp hi=1 drops mti_o next cycle.
REQ-032 Bench SHALL check the carry scenario: write mtime lo=0xFFFFFFFF, hi=0x00000005 -> after one tick, mtime = 0x00000006_00000000.
REQ-033 Bench SHALL check the write-vs-tick scenario: write mtime lo=0x100 with strobes 1111 on a tick cycle -> mtime lo reads 0x100 next cycle, not 0x101.
REQ-034 Bench SHALL check the byte-strobe/msip scenario: write 0xFFFFFFFF to 0x00 with strobes 0001 -> msi_o=1, read 0x00 returns 0x00000001; write 0 -> msi_o=0.
REQ-035 Bench SHALL check the reset-mid-run scenario: mti_o=1 and read pending, assert reset_n=0 asynchronously -> mti_o=0, data_o=0 immediately; after release, mtimecmp reads 0xFFFFFFFF (both halves).

Source files
------------

// File: rtl/clint_timer_if.sv
// clint_timer_if: register bus bundle for the CLINT timer block
interface clint_timer_if;
  logic enable_i;
  logic [3:0] write_enable_i;
  logic [4:0] address_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  modport master (output enable_i, write_enable_i, address_i, data_i, input data_o);
  modport slave (input enable_i, write_enable_i, address_i, data_i, output data_o);
endinterface

// File: rtl/clint_timer.sv
// clint_timer: machine timer (mtime/mtimecmp) and software interrupt (msip) registers
module clint_timer #(
  parameter int unsigned PRESCALER = 1
) (
  input  logic clk,
  input  logic reset_n,
  clint_timer_if.slave bus,
  output logic mti_o,
  output logic msi_o
);
  logic [15:0] pcnt;
  logic [63:0] mtime, mtimecmp, mtime_nx;
  logic msip, tick, rd, wr, wr_lo, wr_hi, unused_addr;
  logic [2:0] sel;
  logic [31:0] rdata;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
  assign unused_addr = ^bus.address_i[1:0];
  assign sel = bus.address_i[4:2];
  assign rd = bus.enable_i && bus.write_enable_i == 4'b0;
  assign wr = bus.enable_i && bus.write_enable_i != 4'b0;
  assign wr_lo = wr && sel == 3'd3;
  assign wr_hi = wr && sel == 3'd4;
  assign tick = pcnt == 16'(PRESCALER - 1);
  assign msi_o = msip;
  always_comb
    rdata = sel == 3'd0 ? {31'b0, msip} :
            sel == 3'd1 ? mtimecmp[31:0] :
            sel == 3'd2 ? mtimecmp[63:32] :
            sel == 3'd3 ? mtime[31:0] :
            sel == 3'd4 ? mtime[63:32] : 32'b0;
  always_comb
    mtime_nx = (wr_lo || wr_hi) ?
               {wr_hi ? merge(mtime[63:32], bus.data_i, bus.write_enable_i) : mtime[63:32],
                wr_lo ? merge(mtime[31:0], bus.data_i, bus.write_enable_i) : mtime[31:0]} :
               tick ? mtime + 64'd1 : mtime;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pcnt <= '0;
      mtime <= '0;
      mtimecmp <= '1;
      msip <= 1'b0;
      mti_o <= 1'b0;
      bus.data_o <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 16'd1;
      mtime <= mtime_nx;
      mti_o <= mtime >= mtimecmp;
      if (rd) bus.data_o <= rdata;
      if (wr && sel == 3'd0 && bus.write_enable_i[0]) msip <= bus.data_i[0];
      if (wr && sel == 3'd1) mtimecmp[31:0] <= merge(mtimecmp[31:0], bus.data_i, bus.write_enable_i);
      if (wr && sel == 3'd2) mtimecmp[63:32] <= merge(mtimecmp[63:32], bus.data_i, bus.write_enable_i);
    end
endmodule
